// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-RAM port (and the boot ROM read path) between
// instruction fetch and data-bus accesses; fetch owns the port by default.
module imem_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int BOOT_BIT     = 31,
  parameter bit BOOT_DEFAULT = 1'b0,
  parameter int REFETCH_OFS  = 1,
  parameter bit BACK2BACK    = 1'b0
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic                if_req_i,
  input  logic [31:0]         if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_valid_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [31:0]         d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_rvalid_o,
  output logic                d_err_o,
  output logic                d_stall_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_q_i,
  input  logic [DATA_W-1:0]   boot_q_i
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DACC    = 2'd1;
  localparam logic [1:0] REFETCH = 2'd2;
  localparam logic [1:0] RESUME  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] saved_addr;
  logic [ADDR_W-1:0] if_waddr, d_waddr;
  logic              dsel, boot_sel;
  logic              port_free, take_d;
  logic              unused_addr_bits;

  assign if_waddr  = if_addr_i[ADDR_W+1:2];
  assign d_waddr   = d_addr_i[ADDR_W+1:2];
  assign port_free = (state == IDLE) || (state == RESUME);
  // A data request is only accepted while fetch owns the port.
  assign take_d    = d_req_i && ((state == IDLE) || ((state == RESUME) && (BACK2BACK != 1'b0)));
  assign unused_addr_bits = ^{if_addr_i, d_addr_i};

  assign if_rdata_o = boot_sel ? boot_q_i : mem_q_i;

  always_comb begin
    mem_addr_o  = if_waddr;
    mem_en_o    = if_req_i;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    d_stall_o   = take_d;
    state_nxt   = take_d ? DACC : IDLE;
    case (state)
      DACC: begin
        mem_addr_o  = d_waddr;
        mem_en_o    = 1'b1;
        mem_we_o    = d_we_i & ~dsel;
        mem_be_o    = d_be_i;
        mem_wdata_o = d_wdata_i;
        d_stall_o   = 1'b1;
        state_nxt   = REFETCH;
      end
      REFETCH: begin
        mem_addr_o = saved_addr;
        mem_en_o   = 1'b1;
        d_stall_o  = 1'b1;
        state_nxt  = RESUME;
      end
      default: ;
    endcase
    // Nothing reaches the macro while reset is asserted, so an aborted write never lands.
    if (!resetn_i) begin
      mem_en_o  = 1'b0;
      mem_we_o  = 1'b0;
      d_stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state      <= IDLE;
      saved_addr <= '0;
      d_rdata_o  <= '0;
      d_rvalid_o <= 1'b0;
      d_err_o    <= 1'b0;
      if_valid_o <= 1'b0;
      boot_sel   <= BOOT_DEFAULT;
      dsel       <= 1'b0;
    end else begin
      state      <= state_nxt;
      d_rvalid_o <= 1'b0;
      d_err_o    <= 1'b0;
      if (take_d) begin
        saved_addr <= if_waddr - ADDR_W'(REFETCH_OFS);
        dsel       <= d_addr_i[BOOT_BIT];
      end
      if (state == REFETCH) begin
        d_rdata_o  <= dsel ? boot_q_i : mem_q_i;
        d_rvalid_o <= 1'b1;
        d_err_o    <= d_we_i & dsel;
      end
      if (port_free && if_req_i)
        boot_sel <= if_addr_i[BOOT_BIT];
      if_valid_o <= (port_free && if_req_i) || (state == REFETCH);
    end
  end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: RAM/ROM models on the port, a word-level
// reference memory, and per-scenario tasks with randomized traffic.
module tb_imem_port_arbiter;
  logic        clk = 1'b0;
  logic        resetn, if_req, d_req, d_we, init_go;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_q, boot_q;
  logic        if_valid, d_rvalid, d_err, d_stall, mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [13:0] mem_addr;
  // second instance with back-to-back enabled, same stimulus
  logic [31:0] b_unused_if_rdata, b_unused_d_rdata, b_unused_wdata;
  logic        b_unused_if_valid, b_unused_err, b_unused_en, b_unused_we;
  logic [3:0]  b_unused_be;
  logic        b_rvalid, b_stall;
  logic [13:0] b_addr;

  logic [31:0] mem_ram [0:16383];
  logic [31:0] ref_ram [0:16383];
  logic [31:0] rom     [0:16383];
  int          wr_cnt = 0;
  int          nvec = 0, nerr = 0;

  logic [3:0]  obs_stall, obs_we, obs_rvalid, obs_err, obs_be;
  logic [13:0] obs_addr [4];
  logic [31:0] obs_rdata, obs_ifr;
  logic        obs_ifv;

  always #5 clk = ~clk;

  imem_port_arbiter dut (
    .clk_i(clk), .resetn_i(resetn), .if_req_i(if_req), .if_addr_i(if_addr),
    .if_rdata_o(if_rdata), .if_valid_o(if_valid), .d_req_i(d_req), .d_we_i(d_we),
    .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_rdata_o(d_rdata),
    .d_rvalid_o(d_rvalid), .d_err_o(d_err), .d_stall_o(d_stall), .mem_en_o(mem_en),
    .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_q_i(mem_q), .boot_q_i(boot_q)
  );

  imem_port_arbiter #(.BACK2BACK(1'b1)) dut_b2b (
    .clk_i(clk), .resetn_i(resetn), .if_req_i(if_req), .if_addr_i(if_addr),
    .if_rdata_o(b_unused_if_rdata), .if_valid_o(b_unused_if_valid), .d_req_i(d_req), .d_we_i(d_we),
    .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_rdata_o(b_unused_d_rdata),
    .d_rvalid_o(b_rvalid), .d_err_o(b_unused_err), .d_stall_o(b_stall), .mem_en_o(b_unused_en),
    .mem_we_o(b_unused_we), .mem_be_o(b_unused_be), .mem_addr_o(b_addr), .mem_wdata_o(b_unused_wdata),
    .mem_q_i(mem_q), .boot_q_i(boot_q)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Word the core expects to read at a byte address.
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return a[31] ? rom[a[15:2]] : ref_ram[a[15:2]];
  endfunction

  // Synchronous RAM / ROM with one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (init_go) mem_ram <= ref_ram;
    else if (mem_en) begin
      if (mem_we) mem_ram[mem_addr] <= merge(mem_ram[mem_addr], mem_wdata, mem_be);
      mem_q  <= mem_ram[mem_addr];
      boot_q <= rom[mem_addr];
    end
    if (mem_we) wr_cnt <= wr_cnt + 1;
  end

  task automatic run_access(input logic we, input logic [3:0] be, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] fa);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        if_req = 1; if_addr = fa; d_req = 1; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
      end
      if (c == 3) d_req = 0;
      @(negedge clk);
      obs_stall[c] = d_stall; obs_we[c] = mem_we; obs_rvalid[c] = d_rvalid; obs_err[c] = d_err;
      obs_addr[c] = mem_addr;
      if (c == 1) obs_be = mem_be;
      if (c == 3) begin obs_rdata = d_rdata; obs_ifv = if_valid; obs_ifr = if_rdata; end
    end
  endtask

  task automatic test_reset();
    resetn = 0; init_go = 1; if_req = 1; d_req = 1; d_we = 1; d_be = 4'hF;
    if_addr = 32'h40; d_addr = 32'h20; d_wdata = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    nvec++; if ({mem_en, mem_we, d_stall} !== 3'b000) begin nerr++; $display("FAIL reset_gating got %b exp 000", {mem_en, mem_we, d_stall}); end
    @(posedge clk); #1; init_go = 0;
    @(negedge clk);
    nvec++; if ({d_rvalid, d_err, if_valid} !== 3'b000) begin nerr++; $display("FAIL reset_flags got %b exp 000", {d_rvalid, d_err, if_valid}); end
    nvec++; if (d_rdata !== 32'h0) begin nerr++; $display("FAIL reset_rdata got %h exp 0", d_rdata); end
    @(posedge clk); #1; resetn = 1; if_req = 0; d_req = 0; d_we = 0;
    @(negedge clk);
    nvec++; if ({mem_en, d_stall} !== 2'b00) begin nerr++; $display("FAIL reset_idle got %b exp 00", {mem_en, d_stall}); end
  endtask

  task automatic test_fetch();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1; if_req = 1; if_addr = 32'h40;
      @(negedge clk);
      nvec++; if ({mem_addr, mem_en, d_stall} !== {14'h10, 1'b1, 1'b0}) begin nerr++; $display("FAIL fetch_port c%0d got %h/%b/%b exp 0010/1/0", c, mem_addr, mem_en, d_stall); end
      nvec++; if (if_valid !== (c != 0)) begin nerr++; $display("FAIL fetch_valid c%0d got %b exp %b", c, if_valid, c != 0); end
      if (c != 0) begin
        nvec++; if (if_rdata !== ref_ram[16'h10]) begin nerr++; $display("FAIL fetch_data got %h exp %h", if_rdata, ref_ram[16'h10]); end
      end
    end
  endtask

  task automatic test_data_read();
    run_access(1'b0, 4'hF, 32'h20, 32'h0, 32'h100);
    nvec++; if ({obs_addr[0], obs_addr[1], obs_addr[2]} !== {14'h40, 14'h08, 14'h3F}) begin nerr++; $display("FAIL rd_addr_seq got %h %h %h exp 0040 0008 003f", obs_addr[0], obs_addr[1], obs_addr[2]); end
    nvec++; if (obs_stall !== 4'b0111) begin nerr++; $display("FAIL rd_stall got %b exp 0111", obs_stall); end
    nvec++; if (obs_rvalid !== 4'b1000) begin nerr++; $display("FAIL rd_rvalid got %b exp 1000", obs_rvalid); end
    nvec++; if (obs_rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_data got %h exp deadbeef", obs_rdata); end
    nvec++; if ({obs_ifv, obs_ifr} !== {1'b1, ref_ram[16'h3F]}) begin nerr++; $display("FAIL rd_refetch got %b/%h exp 1/%h", obs_ifv, obs_ifr, ref_ram[16'h3F]); end
  endtask

  task automatic test_data_write();
    logic [31:0] expw;
    expw = merge(ref_ram[16'h11], 32'h12345678, 4'b0011);
    run_access(1'b1, 4'b0011, 32'h44, 32'h12345678, 32'h100);
    ref_ram[16'h11] = expw;
    nvec++; if (obs_we !== 4'b0010) begin nerr++; $display("FAIL wr_we got %b exp 0010", obs_we); end
    nvec++; if ({obs_be, obs_addr[1]} !== {4'b0011, 14'h11}) begin nerr++; $display("FAIL wr_be_addr got %b/%h exp 0011/0011", obs_be, obs_addr[1]); end
    run_access(1'b0, 4'hF, 32'h44, 32'h0, 32'h100);
    nvec++; if (obs_rdata !== expw) begin nerr++; $display("FAIL wr_readback got %h exp %h", obs_rdata, expw); end
  endtask

  task automatic test_rom();
    int w0;
    w0 = wr_cnt;
    run_access(1'b1, 4'hF, 32'h8000_0010, 32'hBAD0BAD0, 32'h100);
    @(posedge clk); #1; if_req = 0;
    @(negedge clk);
    nvec++; if (obs_we !== 4'b0000 || wr_cnt != w0) begin nerr++; $display("FAIL rom_wr_blocked got we=%b writes=%0d exp 0000/%0d", obs_we, wr_cnt, w0); end
    nvec++; if ({obs_err, d_err} !== 5'b10000) begin nerr++; $display("FAIL rom_err_pulse got %b exp 10000", {obs_err, d_err}); end
    run_access(1'b0, 4'hF, 32'h8000_0010, 32'h0, 32'h100);
    nvec++; if (obs_rdata !== rom[4]) begin nerr++; $display("FAIL rom_read got %h exp %h", obs_rdata, rom[4]); end
    @(posedge clk); #1; if_req = 1; if_addr = 32'h8000_0000;
    @(posedge clk); #1; if_req = 0;
    @(negedge clk);
    nvec++; if ({if_valid, if_rdata} !== {1'b1, rom[0]}) begin nerr++; $display("FAIL rom_fetch got %b/%h exp 1/%h", if_valid, if_rdata, rom[0]); end
  endtask

  task automatic test_wrap();
    run_access(1'b0, 4'hF, 32'h20, 32'h0, 32'h0);
    nvec++; if (obs_addr[2] !== 14'h3FFF) begin nerr++; $display("FAIL wrap_saved got %h exp 3fff", obs_addr[2]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] st_a, st_b, rv_a, rv_b;
    logic [13:0] b_addr4;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h24; end
      if (c == 6) d_req = 0;
      @(negedge clk);
      st_a[c] = d_stall; st_b[c] = b_stall; rv_a[c] = d_rvalid; rv_b[c] = b_rvalid;
      if (c == 4) b_addr4 = b_addr;
    end
    nvec++; if (st_b !== 8'b0011_1111) begin nerr++; $display("FAIL b2b_stall got %b exp 00111111", st_b); end
    nvec++; if (rv_b !== 8'b0100_1000) begin nerr++; $display("FAIL b2b_rvalid got %b exp 01001000", rv_b); end
    nvec++; if (b_addr4 !== 14'h09) begin nerr++; $display("FAIL b2b_dacc_addr got %h exp 0009", b_addr4); end
    nvec++; if (st_a !== 8'b0111_0111) begin nerr++; $display("FAIL nob2b_stall got %b exp 01110111", st_a); end
    nvec++; if (rv_a !== 8'b1000_1000) begin nerr++; $display("FAIL nob2b_rvalid got %b exp 10001000", rv_a); end
  endtask

  task automatic test_random();
    logic        we, rom_d, rom_f, last_req;
    logic [13:0] wa, fw, rw;
    logic [31:0] a, fa, wd, exp_rd, last_addr;
    logic [3:0]  be;
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1)); rom_d = ($urandom_range(0, 3) == 0); rom_f = ($urandom_range(0, 3) == 0);
      wa = 14'($urandom_range(0, 63)); fw = 14'($urandom_range(0, 63));
      a = {rom_d, 15'd0, wa, 2'b00}; fa = {rom_f, 15'd0, fw, 2'b00};
      be = 4'($urandom); wd = $urandom;
      exp_rd = exp_word(a);
      run_access(we, be, a, wd, fa);
      if (we && !rom_d) ref_ram[wa] = merge(ref_ram[wa], wd, be);
      rw = fw - 14'd1;
      nvec++; if ({obs_stall, obs_rvalid} !== 8'b0111_1000) begin nerr++; $display("FAIL rnd_timing n%0d got %b/%b exp 0111/1000", n, obs_stall, obs_rvalid); end
      nvec++; if (obs_we !== ((we && !rom_d) ? 4'b0010 : 4'b0000)) begin nerr++; $display("FAIL rnd_we n%0d got %b", n, obs_we); end
      nvec++; if (obs_err !== ((we && rom_d) ? 4'b1000 : 4'b0000)) begin nerr++; $display("FAIL rnd_err n%0d got %b", n, obs_err); end
      nvec++; if ({obs_addr[1], obs_addr[2]} !== {wa, rw}) begin nerr++; $display("FAIL rnd_addr n%0d got %h/%h exp %h/%h", n, obs_addr[1], obs_addr[2], wa, rw); end
      if (!we) begin
        nvec++; if (obs_rdata !== exp_rd) begin nerr++; $display("FAIL rnd_rdata n%0d got %h exp %h", n, obs_rdata, exp_rd); end
      end
      nvec++; if ({obs_ifv, obs_ifr} !== {1'b1, exp_word({rom_f, 15'd0, rw, 2'b00})}) begin nerr++; $display("FAIL rnd_refetch n%0d got %b/%h", n, obs_ifv, obs_ifr); end
      last_req = 1; last_addr = fa;
      for (int k = $urandom_range(1, 4); k > 0; k--) begin
        @(posedge clk); #1;
        if_req = 1'($urandom_range(0, 1));
        if_addr = {1'($urandom_range(0, 1)), 15'd0, 14'($urandom_range(0, 63)), 2'b00};
        @(negedge clk);
        nvec++; if (if_valid !== last_req || (last_req && if_rdata !== exp_word(last_addr))) begin nerr++; $display("FAIL rnd_fetch n%0d got %b/%h exp %b/%h", n, if_valid, if_rdata, last_req, exp_word(last_addr)); end
        last_req = if_req; last_addr = if_addr;
      end
    end
    @(posedge clk); #1; if_req = 0; d_we = 0;
  endtask

  task automatic test_reset_mid();
    int w0;
    logic [31:0] keep;
    keep = ref_ram[16'h0C];
    @(posedge clk); #1; if_req = 1; if_addr = 32'h8000_0000;
    @(posedge clk); #1; d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h30; d_wdata = 32'h5555AAAA;
    @(posedge clk); #1; resetn = 0; w0 = wr_cnt;
    @(negedge clk);
    nvec++; if ({mem_en, mem_we, d_stall} !== 3'b000) begin nerr++; $display("FAIL rstmid_gating got %b exp 000", {mem_en, mem_we, d_stall}); end
    @(posedge clk); #1; resetn = 1; d_req = 0; if_req = 0; d_we = 0;
    @(negedge clk);
    nvec++; if ({d_rvalid, d_err, if_valid, d_stall, d_rdata} !== 36'h0) begin nerr++; $display("FAIL rstmid_outputs got %b%b%b%b/%h exp 0000/0", d_rvalid, d_err, if_valid, d_stall, d_rdata); end
    nvec++; if (if_rdata !== ref_ram[0]) begin nerr++; $display("FAIL rstmid_bootsel got %h exp %h", if_rdata, ref_ram[0]); end
    @(posedge clk); #1; if_req = 1; if_addr = 32'h200;
    @(negedge clk);
    nvec++; if ({mem_addr, mem_en, d_stall} !== {14'h80, 1'b1, 1'b0}) begin nerr++; $display("FAIL rstmid_idle got %h/%b/%b exp 0080/1/0", mem_addr, mem_en, d_stall); end
    nvec++; if (wr_cnt != w0 || mem_ram[16'h0C] !== keep) begin nerr++; $display("FAIL rstmid_nowrite got %0d/%h exp %0d/%h", wr_cnt, mem_ram[16'h0C], w0, keep); end
    @(posedge clk); #1; if_req = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ref_ram[i] = $urandom & 32'h7FFF_FFFF;
      rom[i]     = $urandom | 32'h8000_0000;
    end
    ref_ram[8] = 32'hDEADBEEF;
    test_reset();
    test_fetch();
    test_data_read();
    test_data_write();
    test_rom();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
